// File: rtl/sbuf_scanout.sv
// Screen buffer with a concurrent write port and an upscaled raster scan-out.
// The frame lives in a read-first dual-port BRAM feeding a small FWFT FIFO.
module sbuf_scanout #(
   parameter int FRAME_WIDTH  = 256,
   parameter int FRAME_HEIGHT = 128,
   parameter int SCALE        = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                                         clk_in,
   input  logic                                         rst_n_in,
   input  logic [15:0]                                  sbuf_data,
   input  logic [$clog2(FRAME_WIDTH*FRAME_HEIGHT)-1:0]  sbuf_addr,
   input  logic                                         sbuf_write_enable,
   input  logic                                         px_ready,
   output logic                                         px_valid,
   output logic [15:0]                                  px_data,
   output logic                                         px_sof,
   output logic                                         px_eol
);
   localparam int AW = $clog2(FRAME_WIDTH*FRAME_HEIGHT);
   localparam int XW = $clog2(FRAME_WIDTH);
   localparam int YW = $clog2(FRAME_HEIGHT);
   localparam int RW = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
   localparam logic [RW-1:0] R_LAST = RW'(SCALE - 1);
   localparam logic [PW-1:0] P_LAST = PW'(FIFO_DEPTH - 1);

   logic [15:0]   mem [FRAME_WIDTH*FRAME_HEIGHT];

   logic [XW-1:0] sx;
   logic [YW-1:0] sy;
   logic [RW-1:0] rx;
   logic [RW-1:0] ry;

   logic          v1, v2, s1, s2, e1, e2;
   logic [15:0]   d1, d2;

   logic [15:0]   fd [FIFO_DEPTH];
   logic          fs [FIFO_DEPTH];
   logic          fe [FIFO_DEPTH];
   logic [PW-1:0] wp, rp;
   logic [CW-1:0] cnt;

   logic          issue;
   logic          pop;
   logic [AW-1:0] raddr;
   logic          sof_n;
   logic          eol_n;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == P_LAST) ? '0 : p + 1'b1;
   endfunction

   // Credit counts queued words plus reads still in the BRAM pipeline.
   assign issue = (int'(cnt) + int'(v1) + int'(v2)) < FIFO_DEPTH;
   assign raddr = {sy, sx};
   assign sof_n = (sx == '0) && (sy == '0) && (rx == '0) && (ry == '0);
   assign eol_n = (sx == X_LAST) && (rx == R_LAST);

   assign px_valid = (cnt != '0);
   assign pop      = px_valid && px_ready;
   assign px_data  = px_valid ? fd[rp] : '0;
   assign px_sof   = px_valid && fs[rp];
   assign px_eol   = px_valid && fe[rp];

   // Nonblocking read beside the write gives read-first collisions.
   always_ff @(posedge clk_in) begin
      if (sbuf_write_enable)
         mem[sbuf_addr] <= sbuf_data;
      if (issue)
         d1 <= mem[raddr];
      d2 <= d1;
   end

   always_ff @(posedge clk_in) begin
      if (v2) begin
         fd[wp] <= d2;
         fs[wp] <= s2;
         fe[wp] <= e2;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sx  <= '0;
         sy  <= '0;
         rx  <= '0;
         ry  <= '0;
         v1  <= 1'b0;
         v2  <= 1'b0;
         s1  <= 1'b0;
         s2  <= 1'b0;
         e1  <= 1'b0;
         e2  <= 1'b0;
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         v1 <= issue;
         s1 <= sof_n;
         e1 <= eol_n;
         v2 <= v1;
         s2 <= s1;
         e2 <= e1;
         if (issue) begin
            if (rx == R_LAST) begin
               rx <= '0;
               sx <= sx + 1'b1;
               if (sx == X_LAST) begin
                  if (ry == R_LAST) begin
                     ry <= '0;
                     sy <= sy + 1'b1;
                  end else begin
                     ry <= ry + 1'b1;
                  end
               end
            end else begin
               rx <= rx + 1'b1;
            end
         end
         if (v2)
            wp <= inc(wp);
         if (pop)
            rp <= inc(rp);
         cnt <= cnt + CW'(v2) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_sbuf_scanout.sv
// Directed bench for sbuf_scanout on a reduced 16x8 frame, scale 2.
// Expected words come from a shadow copy of the frame and the raster formula.
module tb_sbuf_scanout;
   localparam int W     = 16;
   localparam int H     = 8;
   localparam int S     = 2;
   localparam int D     = 4;
   localparam int LINE  = W * S;
   localparam int FRAME = W * S * H * S;
   localparam int AW    = $clog2(W * H);

   logic          clk;
   logic          rst_n;
   logic [15:0]   sbuf_data;
   logic [AW-1:0] sbuf_addr;
   logic          sbuf_write_enable;
   logic          px_ready;
   logic          px_valid;
   logic [15:0]   px_data;
   logic          px_sof;
   logic          px_eol;

   int            total;
   int            bad;
   int            k;
   logic [15:0]   model [W*H];

   sbuf_scanout #(
      .FRAME_WIDTH (W),
      .FRAME_HEIGHT(H),
      .SCALE       (S),
      .FIFO_DEPTH  (D)
   ) dut (
      .clk_in           (clk),
      .rst_n_in         (rst_n),
      .sbuf_data        (sbuf_data),
      .sbuf_addr        (sbuf_addr),
      .sbuf_write_enable(sbuf_write_enable),
      .px_ready         (px_ready),
      .px_valid         (px_valid),
      .px_data          (px_data),
      .px_sof           (px_sof),
      .px_eol           (px_eol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int addr_of(input int n);
      int f;
      f = n % FRAME;
      return ((f / LINE) / S) * W + (f % LINE) / S;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      px_ready = 1'b1;
      for (int a = 0; a < W * H; a++) begin
         sbuf_addr = AW'(a);
         sbuf_data = 16'h5000 | 16'(a);
         sbuf_write_enable = 1'b1;
         model[a] = 16'h5000 | 16'(a);
         step();
         total++;
         if (px_valid !== 1'b0 || px_data !== 16'h0 ||
             px_sof !== 1'b0 || px_eol !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d valid=%b data=%h sof=%b eol=%b",
                     a, px_valid, px_data, px_sof, px_eol);
         end
      end
      sbuf_write_enable = 1'b0;
      rst_n = 1'b1;
      for (int e = 1; e <= 2; e++) begin
         step();
         total++;
         if (px_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_early edge=%0d valid=%b want=0", e, px_valid);
         end
      end
      step();
      total++;
      if (px_valid !== 1'b1 || px_sof !== 1'b1 || px_data !== 16'h5000) begin
         bad++;
         $display("FAIL reset_first valid=%b sof=%b data=%h want 1 1 5000",
                  px_valid, px_sof, px_data);
      end
      k = 0;
   endtask

   task automatic test_raster();
      int cyc;
      cyc = 0;
      px_ready = 1'b1;
      while (k < 2 * FRAME && cyc < 4 * FRAME) begin
         total++;
         if (px_valid !== 1'b1) begin
            bad++;
            $display("FAIL raster_bubble k=%0d valid=%b want=1", k, px_valid);
         end else begin
            total++;
            if (px_data !== model[addr_of(k)] ||
                px_sof !== ((k % FRAME) == 0) ||
                px_eol !== ((k % LINE) == LINE - 1)) begin
               bad++;
               $display("FAIL raster k=%0d got=%h/%b/%b want=%h/%b/%b",
                        k, px_data, px_sof, px_eol, model[addr_of(k)],
                        (k % FRAME) == 0, (k % LINE) == LINE - 1);
            end
            k++;
         end
         step();
         cyc++;
      end
      total++;
      if (k < 2 * FRAME) begin
         bad++;
         $display("FAIL raster_timeout words=%0d want=%0d", k, 2 * FRAME);
      end
   endtask

   task automatic test_backpressure();
      int          cyc;
      int          target;
      logic        r;
      logic        stall;
      logic [15:0] pd;
      logic        ps;
      logic        pe;
      cyc = 0;
      target = k + FRAME;
      stall = 1'b0;
      pd = '0;
      ps = 1'b0;
      pe = 1'b0;
      while (k < target && cyc < 20000) begin
         if (stall) begin
            total++;
            if (px_valid !== 1'b1 || px_data !== pd ||
                px_sof !== ps || px_eol !== pe) begin
               bad++;
               $display("FAIL stall_hold k=%0d got=%b/%h/%b/%b want=1/%h/%b/%b",
                        k, px_valid, px_data, px_sof, px_eol, pd, ps, pe);
            end
         end
         r = ($urandom_range(0, 9) < 3);
         px_ready = r;
         if (px_valid === 1'b1 && r) begin
            total++;
            if (px_data !== model[addr_of(k)] ||
                px_sof !== ((k % FRAME) == 0) ||
                px_eol !== ((k % LINE) == LINE - 1)) begin
               bad++;
               $display("FAIL backpressure k=%0d got=%h/%b/%b want=%h",
                        k, px_data, px_sof, px_eol, model[addr_of(k)]);
            end
            k++;
         end
         stall = (px_valid === 1'b1) && !r;
         pd = px_data;
         ps = px_sof;
         pe = px_eol;
         step();
         cyc++;
      end
      px_ready = 1'b1;
      total++;
      if (k < target) begin
         bad++;
         $display("FAIL backpressure_timeout words=%0d want=%0d", k, target);
      end
   endtask

   task automatic test_collision();
      int          cyc;
      logic [15:0] want;
      px_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      total++;
      if (px_valid !== 1'b0) begin
         bad++;
         $display("FAIL collision_rst valid=%b want=0", px_valid);
      end
      sbuf_addr = '0;
      sbuf_data = 16'h1111;
      sbuf_write_enable = 1'b1;
      step();
      rst_n = 1'b1;
      sbuf_data = 16'hBEEF;
      step();
      sbuf_write_enable = 1'b0;
      model[0] = 16'hBEEF;
      step();
      step();
      k = 0;
      cyc = 0;
      while (k < FRAME + 2 && cyc < 4 * FRAME) begin
         if (px_valid === 1'b1) begin
            want = (k == 0) ? 16'h1111 : model[addr_of(k)];
            total++;
            if (px_data !== want || px_sof !== ((k % FRAME) == 0)) begin
               bad++;
               $display("FAIL collision k=%0d got=%h/%b want=%h/%b",
                        k, px_data, px_sof, want, (k % FRAME) == 0);
            end
            k++;
         end
         step();
         cyc++;
      end
      total++;
      if (k < FRAME + 2) begin
         bad++;
         $display("FAIL collision_timeout words=%0d", k);
      end
   endtask

   task automatic test_concurrent();
      int          cyc;
      int          target;
      int          a;
      logic [15:0] nv;
      cyc = 0;
      target = k + FRAME;
      px_ready = 1'b1;
      while (k < target && cyc < 4 * FRAME) begin
         if (cyc < W * H) begin
            sbuf_addr = AW'(cyc);
            sbuf_data = 16'hC000 | 16'(cyc);
            sbuf_write_enable = 1'b1;
         end else begin
            sbuf_write_enable = 1'b0;
         end
         if (px_valid === 1'b1) begin
            a = addr_of(k);
            nv = 16'hC000 | 16'(a);
            total++;
            if ($isunknown(px_data)) begin
               bad++;
               $display("FAIL concurrent_x k=%0d data=%h", k, px_data);
            end
            total++;
            if (px_data !== model[a] && px_data !== nv) begin
               bad++;
               $display("FAIL concurrent k=%0d got=%h want=%h or %h",
                        k, px_data, model[a], nv);
            end
            k++;
         end
         step();
         cyc++;
      end
      sbuf_write_enable = 1'b0;
      for (int i = 0; i < W * H; i++)
         model[i] = 16'hC000 | 16'(i);
      total++;
      if (k < target) begin
         bad++;
         $display("FAIL concurrent_timeout words=%0d", k);
      end
   endtask

   task automatic test_midreset();
      int cyc;
      cyc = 0;
      px_ready = 1'b1;
      while ((k % FRAME) != 300 && cyc < 4 * FRAME) begin
         if (px_valid === 1'b1 && (k % FRAME) != 300)
            k++;
         if ((k % FRAME) != 300) begin
            step();
            cyc++;
         end
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (px_valid !== 1'b0 || px_sof !== 1'b0 || px_data !== 16'h0) begin
         bad++;
         $display("FAIL midreset_async valid=%b sof=%b data=%h want 0 0 0000",
                  px_valid, px_sof, px_data);
      end
      step();
      rst_n = 1'b1;
      for (int e = 1; e <= 2; e++) begin
         step();
         total++;
         if (px_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_early edge=%0d valid=%b want=0", e, px_valid);
         end
      end
      step();
      total++;
      if (px_valid !== 1'b1 || px_sof !== 1'b1 || px_data !== model[0]) begin
         bad++;
         $display("FAIL midreset_restart valid=%b sof=%b data=%h want 1 1 %h",
                  px_valid, px_sof, px_data, model[0]);
      end
      k = 0;
      cyc = 0;
      while (k < 2 * LINE && cyc < 8 * LINE) begin
         if (px_valid === 1'b1) begin
            total++;
            if (px_data !== model[addr_of(k)] ||
                px_sof !== (k == 0) ||
                px_eol !== ((k % LINE) == LINE - 1)) begin
               bad++;
               $display("FAIL midreset_stream k=%0d got=%h/%b/%b want=%h",
                        k, px_data, px_sof, px_eol, model[addr_of(k)]);
            end
            k++;
         end
         step();
         cyc++;
      end
      total++;
      if (k < 2 * LINE) begin
         bad++;
         $display("FAIL midreset_timeout words=%0d", k);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      k = 0;
      rst_n = 1'b0;
      px_ready = 1'b1;
      sbuf_data = '0;
      sbuf_addr = '0;
      sbuf_write_enable = 1'b0;
      test_reset();
      test_raster();
      test_backpressure();
      test_collision();
      test_concurrent();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
